pref_req_port: RTL and testbench
================================

PREF_REQ_PORT -- requirements
Module: pref_req_port

Interface
REQ-001 Parameter addr_width, default 32, meaning address and pc width.
REQ-002 Parameter FIFO_DEPTH, default 4, meaning request FIFO entries; power of 2, at least 2.
REQ-003 Parameter TRACK_N, default 4, meaning entries in the issued-prefetch tracking table.
REQ-004 Port clk, input, 1, clock; the block has one clock and all logic is posedge clk.
REQ-005 Port rst, input, 1, reset; synchronous, active-high.
REQ-006 Ports req, naddr_valid, naddr_pdc, req_pc, req_type: inputs of widths 1, 1, addr_width, addr_width, 1; the prefetch request from a predictor (type 0 = inst, 1 = data).
REQ-007 Ports l2_valid, l2_addr, l2_type: outputs of widths 1, addr_width, 1; the prefetch issue to L2.
REQ-008 Port l2_ready, input, 1, meaning L2 accepts the issue.
REQ-009 Ports ev_valid, ev_addr, ev_pref_unused: inputs of widths 1, addr_width, 1; L2 eviction report, where ev_pref_unused means the line was prefetched and never hit.
REQ-010 Ports anneal_addr, anneal_pc, anneal_unhit, anneal_type: outputs of widths addr_width, addr_width, 1, 1; annealing feedback to the predictor.

Function
REQ-011 A request is offered when req & naddr_valid is 1 in a cycle.
REQ-012 Dedup: an offered request is dropped if naddr_pdc equals any valid FIFO entry address or any valid tracking entry address.
REQ-013 FIFO full: an offered request is dropped, except when a dequeue occurs in the same cycle, in which case it is accepted.
REQ-014 An accepted request enqueues {naddr_pdc, req_pc, req_type}, and the FIFO pointers wrap modulo FIFO_DEPTH.
REQ-015 The issue FSM has two states, IDLE and ISSUE.
REQ-016 IDLE -> ISSUE when the FIFO is non-empty; the head is loaded into the output registers and l2_valid=1 from the next cycle.
REQ-017 In ISSUE, l2_valid stays 1 and l2_addr and l2_type stay stable until l2_ready=1.
REQ-018 The handshake completes at the l2_valid & l2_ready edge, which pops the FIFO and writes {addr, pc, type} into the tracking table.
REQ-019 After a completed handshake the FSM goes ISSUE -> ISSUE with the new head if the FIFO is non-empty after the pop, otherwise ISSUE -> IDLE; this allows back-to-back issue of one per cycle after the first.
REQ-020 Tracking table allocation: the first invalid entry is used, otherwise the entry at the round-robin pointer is overwritten; the pointer advances modulo TRACK_N on each overwrite.
REQ-021 An eviction report with ev_valid & ev_pref_unused & (ev_addr matches a valid entry) invalidates that entry; on the next cycle, anneal_unhit=1 for exactly one cycle with anneal_addr=ev_addr, anneal_pc=stored pc and anneal_type=stored type.
REQ-022 An eviction with no table match, or with ev_pref_unused=0 and a match, invalidates the matching entry if any and produces no anneal pulse.
REQ-023 When a table write and an eviction invalidate hit the same entry in the same cycle, the write wins.
REQ-024 When no anneal pulse is active, anneal_addr, anneal_pc and anneal_type hold their last values and anneal_unhit=0.

Reset
REQ-025 While rst=1: FIFO empty, pointers 0, all tracking entries invalid, FSM=IDLE, and every output is 0.
REQ-026 A reset asserted mid-handshake drops the in-flight issue and all queued requests; l2_valid=0 on the cycle after the rst edge.

Configuration
REQ-027 With PREF_STAT_EN defined: outputs stat_issued, stat_dropped and stat_anneal (32-bit each, saturating, reset to 0) count completed handshakes, dropped requests (dedup plus full) and anneal pulses.
REQ-028 Without PREF_STAT_EN: those ports and counters are absent and all other behaviour is identical.

Structure
REQ-029 A shared package holds the FIFO/track entry struct {addr, pc, type}, the FSM state enum and the PREF_TYPE_INST/PREF_TYPE_DATA constants.
REQ-030 There is one sub-module, pref_fifo (synchronous FIFO, with a combinational per-entry address-compare output for dedup).

Verification
REQ-031 Offer 0x100 with l2_ready=1 -> l2_valid at cycle+2, l2_addr=0x100, and it is tracked.
REQ-032 Offer 0x200 twice while the first is queued (l2_ready=0) -> one FIFO entry; stat_dropped=1.
REQ-033 l2_ready=0 with 5 distinct offers, FIFO_DEPTH=4 -> 4 queued and the 5th dropped; l2_addr stays at the first address until ready.
REQ-034 Issue 0x300 with pc 0x40, then ev_valid, ev_addr=0x300, ev_pref_unused=1 -> next cycle anneal_unhit=1, anneal_pc=0x40, anneal_type=0, and the entry is freed.
REQ-035 Fill the table with 4 entries, issue a 5th -> the entry at the round-robin pointer is overwritten; an eviction of the overwritten address gives no anneal.
REQ-036 Assert rst during l2_valid=1 -> all outputs 0 and the FIFO empty the next cycle; no anneal.

Source files
------------

// File: rtl/pref_req_port_pkg.sv
// Shared types for the prefetch request port: queue/track entry,
// issue FSM state and prefetch type constants.
package pref_req_port_pkg;

  // Widest address/pc the entry struct can carry.
  localparam int PREF_AW = 32;

  localparam logic PREF_TYPE_INST = 1'b0;
  localparam logic PREF_TYPE_DATA = 1'b1;

  typedef struct packed {
    logic [PREF_AW-1:0] addr;
    logic [PREF_AW-1:0] pc;
    logic               typ;
  } pref_ent_t;

  typedef enum logic {
    IDLE,
    ISSUE
  } pref_state_e;

endpackage

// File: rtl/pref_fifo.sv
// Synchronous request FIFO with a per-entry address compare
// used to drop duplicate prefetch requests.
module pref_fifo
  import pref_req_port_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  pref_ent_t          wdata,
  input  logic               pop,
  input  logic [PREF_AW-1:0] cmp_addr,
  output logic [DEPTH-1:0]   cmp_hit,
  output pref_ent_t          head,
  output pref_ent_t          head_nxt,
  output logic               empty,
  output logic               full,
  output logic               multi
);

  localparam int PW = $clog2(DEPTH);

  pref_ent_t       mem [DEPTH];
  logic [PW-1:0]   rd_q;
  logic [PW-1:0]   wr_q;
  logic [PW-1:0]   rd_n;
  logic [PW:0]     cnt_q;
  logic [PW-1:0]   off [DEPTH];

  assign rd_n     = rd_q + 1'b1;
  assign head     = mem[rd_q];
  assign head_nxt = mem[rd_n];
  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == (PW+1)'(DEPTH));
  assign multi    = (cnt_q >= (PW+1)'(2));

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_n;
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Entry storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= wdata;
  end

  // An entry is live when its distance from the head is below the count.
  always_comb begin
    cmp_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off[i]     = PW'(i) - rd_q;
      cmp_hit[i] = ({1'b0, off[i]} < cnt_q) &&
                   (mem[i].addr == cmp_addr);
    end
  end

endmodule

// File: rtl/pref_req_port.sv
// Prefetch request port: dedup/queue predictor requests, issue to L2,
// track issued lines and report unused evictions. Option: PREF_STAT_EN.
module pref_req_port
  import pref_req_port_pkg::*;
#(
  parameter int addr_width = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TRACK_N    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  naddr_valid,
  input  logic [addr_width-1:0] naddr_pdc,
  input  logic [addr_width-1:0] req_pc,
  input  logic                  req_type,
  output logic                  l2_valid,
  output logic [addr_width-1:0] l2_addr,
  output logic                  l2_type,
  input  logic                  l2_ready,
  input  logic                  ev_valid,
  input  logic [addr_width-1:0] ev_addr,
  input  logic                  ev_pref_unused,
  output logic [addr_width-1:0] anneal_addr,
  output logic [addr_width-1:0] anneal_pc,
  output logic                  anneal_unhit,
  output logic                  anneal_type
`ifdef PREF_STAT_EN
  ,
  output logic [31:0]           stat_issued,
  output logic [31:0]           stat_dropped,
  output logic [31:0]           stat_anneal
`endif
);

  localparam int TW = (TRACK_N > 1) ? $clog2(TRACK_N) : 1;

  logic                  offer;
  logic                  dup;
  logic                  accept;
  logic                  pop;
  pref_ent_t             req_ent;
  pref_ent_t             head;
  pref_ent_t             head_nxt;
  pref_ent_t             iss_q;
  pref_ent_t             iss_d;
  logic                  f_empty;
  logic                  f_full;
  logic                  f_multi;
  logic [FIFO_DEPTH-1:0] f_hit;
  pref_state_e           state_q;
  pref_state_e           state_d;

  pref_ent_t             trk [TRACK_N];
  logic [TRACK_N-1:0]    trk_v;
  logic [TRACK_N-1:0]    t_hit;
  logic [TRACK_N-1:0]    ev_hit;
  logic [TRACK_N-1:0]    wr_mask;
  logic [TW-1:0]         rr_q;
  logic [TW-1:0]         w_idx;
  logic                  free_found;
  logic                  pulse;
  logic [PREF_AW-1:0]    ev_cmp;
  pref_ent_t             ev_sel;

  assign req_ent = '{addr: PREF_AW'(naddr_pdc),
                     pc:   PREF_AW'(req_pc),
                     typ:  req_type};
  assign ev_cmp  = PREF_AW'(ev_addr);

  assign offer  = req & naddr_valid;
  assign dup    = (|f_hit) | (|t_hit);
  assign pop    = (state_q == ISSUE) & l2_ready;
  assign accept = offer & ~dup & (~f_full | pop);
  assign pulse  = ev_pref_unused & (|ev_hit);

  assign l2_valid = (state_q == ISSUE);
  assign l2_addr  = addr_width'(iss_q.addr);
  assign l2_type  = iss_q.typ;

  pref_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (accept),
    .wdata    (req_ent),
    .pop      (pop),
    .cmp_addr (req_ent.addr),
    .cmp_hit  (f_hit),
    .head     (head),
    .head_nxt (head_nxt),
    .empty    (f_empty),
    .full     (f_full),
    .multi    (f_multi)
  );

  // Issue state and the held L2 request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      iss_q   <= '0;
    end else begin
      state_q <= state_d;
      iss_q   <= iss_d;
    end
  end

  // Next head after a pop comes from the FIFO, or straight from a
  // same-cycle push when the popped entry was the last one.
  always_comb begin
    state_d = state_q;
    iss_d   = iss_q;
    unique case (state_q)
      IDLE: begin
        if (!f_empty) begin
          state_d = ISSUE;
          iss_d   = head;
        end
      end
      ISSUE: begin
        if (l2_ready) begin
          if (f_multi) begin
            iss_d = head_nxt;
          end else if (accept) begin
            iss_d = req_ent;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Tracking-table address compares for dedup and evictions.
  always_comb begin
    t_hit  = '0;
    ev_hit = '0;
    ev_sel = '0;
    for (int i = 0; i < TRACK_N; i++) begin
      t_hit[i]  = trk_v[i] && (trk[i].addr == req_ent.addr);
      ev_hit[i] = ev_valid && trk_v[i] &&
                  (trk[i].addr == ev_cmp);
      if (ev_hit[i]) ev_sel = trk[i];
    end
  end

  // Allocation: first free slot, else the round-robin victim.
  always_comb begin
    free_found = 1'b0;
    w_idx      = rr_q;
    wr_mask    = '0;
    for (int i = 0; i < TRACK_N; i++) begin
      if (!free_found && !trk_v[i]) begin
        free_found = 1'b1;
        w_idx      = TW'(i);
      end
    end
    if (pop) wr_mask[w_idx] = 1'b1;
  end

  // Valid bits: a write on the same slot beats an eviction clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      trk_v <= '0;
      rr_q  <= '0;
    end else begin
      trk_v <= (trk_v & ~ev_hit) | wr_mask;
      if (pop && !free_found) begin
        rr_q <= (rr_q == TW'(TRACK_N-1)) ? '0 : rr_q + 1'b1;
      end
    end
  end

  // Table payload; validity is carried by trk_v.
  always_ff @(posedge clk) begin
    if (pop) trk[w_idx] <= iss_q;
  end

  // One-cycle anneal pulse; payload holds between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      anneal_unhit <= 1'b0;
      anneal_addr  <= '0;
      anneal_pc    <= '0;
      anneal_type  <= PREF_TYPE_INST;
    end else begin
      anneal_unhit <= pulse;
      if (pulse) begin
        anneal_addr <= ev_addr;
        anneal_pc   <= addr_width'(ev_sel.pc);
        anneal_type <= ev_sel.typ;
      end
    end
  end

`ifdef PREF_STAT_EN
  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_issued  <= '0;
      stat_dropped <= '0;
      stat_anneal  <= '0;
    end else begin
      if (pop && stat_issued != 32'hFFFF_FFFF)
        stat_issued <= stat_issued + 1'b1;
      if (offer && !accept && stat_dropped != 32'hFFFF_FFFF)
        stat_dropped <= stat_dropped + 1'b1;
      if (pulse && stat_anneal != 32'hFFFF_FFFF)
        stat_anneal <= stat_anneal + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pref_req_port.sv
// Directed bench for pref_req_port: cycle table plus
// hand sequences for full FIFO, round-robin overwrite and reset.
module tb_pref_req_port;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic        clk;
  logic        rst;
  logic        req;
  logic        naddr_valid;
  logic [31:0] naddr_pdc;
  logic [31:0] req_pc;
  logic        req_type;
  logic        l2_valid;
  logic [31:0] l2_addr;
  logic        l2_type;
  logic        l2_ready;
  logic        ev_valid;
  logic [31:0] ev_addr;
  logic        ev_pref_unused;
  logic [31:0] anneal_addr;
  logic [31:0] anneal_pc;
  logic        anneal_unhit;
  logic        anneal_type;
`ifdef PREF_STAT_EN
  logic [31:0] stat_issued;
  logic [31:0] stat_dropped;
  logic [31:0] stat_anneal;
`endif

  int checks;
  int errors;

  pref_req_port dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .naddr_valid    (naddr_valid),
    .naddr_pdc      (naddr_pdc),
    .req_pc         (req_pc),
    .req_type       (req_type),
    .l2_valid       (l2_valid),
    .l2_addr        (l2_addr),
    .l2_type        (l2_type),
    .l2_ready       (l2_ready),
    .ev_valid       (ev_valid),
    .ev_addr        (ev_addr),
    .ev_pref_unused (ev_pref_unused),
    .anneal_addr    (anneal_addr),
    .anneal_pc      (anneal_pc),
    .anneal_unhit   (anneal_unhit),
    .anneal_type    (anneal_type)
`ifdef PREF_STAT_EN
    ,
    .stat_issued    (stat_issued),
    .stat_dropped   (stat_dropped),
    .stat_anneal    (stat_anneal)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rq;
    logic        nv;
    logic [31:0] a;
    logic [31:0] pc;
    logic        t;
    logic        rdy;
    logic        ev;
    logic [31:0] ea;
    logic        eu;
    logic        xv;
    logic [31:0] xa;
    logic        xt;
    logic        xu;
    logic [31:0] xaa;
    logic [31:0] xap;
    logic        xat;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tg,
                         input logic v,
                         input logic [31:0] a,
                         input logic t,
                         input logic u,
                         input logic [31:0] aa,
                         input logic [31:0] ap,
                         input logic at);
    chk({tg, ".l2_valid"}, 32'(l2_valid), 32'(v));
    chk({tg, ".l2_addr"}, l2_addr, a);
    chk({tg, ".l2_type"}, 32'(l2_type), 32'(t));
    chk({tg, ".an_unhit"}, 32'(anneal_unhit), 32'(u));
    chk({tg, ".an_addr"}, anneal_addr, aa);
    chk({tg, ".an_pc"}, anneal_pc, ap);
    chk({tg, ".an_type"}, 32'(anneal_type), 32'(at));
  endtask

  task automatic drive(input logic rq, input logic nv,
                       input logic [31:0] a,
                       input logic [31:0] pc,
                       input logic t, input logic rdy,
                       input logic ev,
                       input logic [31:0] ea,
                       input logic eu);
    req            = rq;
    naddr_valid    = nv;
    naddr_pdc      = a;
    req_pc         = pc;
    req_type       = t;
    l2_ready       = rdy;
    ev_valid       = ev;
    ev_addr        = ea;
    ev_pref_unused = eu;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pc_of(input logic [31:0] a);
    return a + 32'h8000;
  endfunction

  task automatic offer(input logic [31:0] a, input logic rdy);
    drive(H, H, a, pc_of(a), a[4], rdy, L, '0, L);
  endtask

  task automatic idle(input logic rdy);
    drive(L, L, '0, '0, L, rdy, L, '0, L);
  endtask

  task automatic evict(input logic [31:0] a, input logic u);
    drive(L, L, '0, '0, L, L, H, a, u);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(L);
    idle(L);
    rst = 1'b0;
  endtask

  logic [31:0] seq_a [4];

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    req = 1'b0; naddr_valid = 1'b0; naddr_pdc = '0;
    req_pc = '0; req_type = 1'b0; l2_ready = 1'b0;
    ev_valid = 1'b0; ev_addr = '0; ev_pref_unused = 1'b0;

    tbl = '{
      '{H,H,'h100,'h10,H,H, L,'h0,L,   L,'h0,L,   L,'h0,'h0,L},
      '{H,L,'h150,'h11,L,H, L,'h0,L,   H,'h100,H, L,'h0,'h0,L},
      '{L,L,'h0,'h0,L,H,    L,'h0,L,   L,'h100,H, L,'h0,'h0,L},
      '{H,H,'h100,'h12,L,H, L,'h0,L,   L,'h100,H, L,'h0,'h0,L},
      '{L,L,'h0,'h0,L,H,    L,'h0,L,   L,'h100,H, L,'h0,'h0,L},
      '{H,H,'h300,'h40,L,L, L,'h0,L,   L,'h100,H, L,'h0,'h0,L},
      '{L,L,'h0,'h0,L,L,    L,'h0,L,   H,'h300,L, L,'h0,'h0,L},
      '{L,L,'h0,'h0,L,L,    L,'h0,L,   H,'h300,L, L,'h0,'h0,L},
      '{L,L,'h0,'h0,L,H,    L,'h0,L,   L,'h300,L, L,'h0,'h0,L},
      '{L,L,'h0,'h0,L,L,    H,'h300,H, L,'h300,L, H,'h300,'h40,L},
      '{L,L,'h0,'h0,L,L,    L,'h0,L,   L,'h300,L, L,'h300,'h40,L},
      '{L,L,'h0,'h0,L,L,    H,'h300,H, L,'h300,L, L,'h300,'h40,L},
      '{H,H,'h300,'h44,H,H, L,'h0,L,   L,'h300,L, L,'h300,'h40,L},
      '{L,L,'h0,'h0,L,H,    L,'h0,L,   H,'h300,H, L,'h300,'h40,L},
      '{L,L,'h0,'h0,L,H,    L,'h0,L,   L,'h300,H, L,'h300,'h40,L},
      '{L,L,'h0,'h0,L,L,    H,'h100,L, L,'h300,H, L,'h300,'h40,L},
      '{L,L,'h0,'h0,L,L,    H,'h100,H, L,'h300,H, L,'h300,'h40,L},
      '{L,L,'h0,'h0,L,L,    H,'h300,H, L,'h300,H, H,'h300,'h44,H}
    };

    // Reset state.
    idle(L);
    idle(L);
    chk_all("rst0", L, '0, L, L, '0, '0, L);
    rst = 1'b0;

    // Cycle table: issue, dedup, anneal, free, re-issue.
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].rq, tbl[i].nv, tbl[i].a, tbl[i].pc,
            tbl[i].t, tbl[i].rdy, tbl[i].ev, tbl[i].ea,
            tbl[i].eu);
      chk_all($sformatf("row%0d", i), tbl[i].xv, tbl[i].xa,
              tbl[i].xt, tbl[i].xu, tbl[i].xaa,
              tbl[i].xap, tbl[i].xat);
    end

    // Dup drop, full drop, accept-on-pop, back-to-back issue.
    do_reset();
    offer(32'h200, L);
    chk("a.first_v", 32'(l2_valid), 32'd0);
    offer(32'h200, L);
    chk("a.load_v", 32'(l2_valid), 32'd1);
    chk("a.load_a", l2_addr, 32'h200);
    offer(32'h210, L);
    offer(32'h220, L);
    offer(32'h230, L);
    offer(32'h240, L);
    idle(L);
    chk("a.hold_v", 32'(l2_valid), 32'd1);
    chk("a.hold_a", l2_addr, 32'h200);
    offer(32'h240, H);
    seq_a = '{32'h210, 32'h220, 32'h230, 32'h240};
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("a.b2b%0d_v", i), 32'(l2_valid), 32'd1);
      chk($sformatf("a.b2b%0d_a", i), l2_addr, seq_a[i]);
      chk($sformatf("a.b2b%0d_t", i), 32'(l2_type),
          32'(seq_a[i][4]));
      idle(H);
    end
    chk("a.drain_v", 32'(l2_valid), 32'd0);
`ifdef PREF_STAT_EN
    chk("a.st_iss", stat_issued, 32'd5);
    chk("a.st_drop", stat_dropped, 32'd2);
`endif

    // Table now 240,210,220,230: 200 was overwritten.
    evict(32'h200, H);
    chk("b.ovw_u", 32'(anneal_unhit), 32'd0);
    chk("b.ovw_aa", anneal_addr, 32'h0);
    evict(32'h210, H);
    chk("b.hit_u", 32'(anneal_unhit), 32'd1);
    chk("b.hit_aa", anneal_addr, 32'h210);
    chk("b.hit_ap", anneal_pc, 32'h8210);
    chk("b.hit_at", 32'(anneal_type), 32'd1);
    offer(32'h240, H);
    idle(H);
    chk("b.dup_v", 32'(l2_valid), 32'd0);
    offer(32'h200, H);
    idle(H);
    chk("b.reiss_v", 32'(l2_valid), 32'd1);
    chk("b.reiss_a", l2_addr, 32'h200);
    idle(H);
    chk("b.done_v", 32'(l2_valid), 32'd0);
`ifdef PREF_STAT_EN
    chk("b.st_iss", stat_issued, 32'd6);
    chk("b.st_drop", stat_dropped, 32'd3);
    chk("b.st_ann", stat_anneal, 32'd1);
`endif

    // Reset in the middle of an issue, with an eviction pending.
    offer(32'h710, L);
    offer(32'h720, L);
    chk("c.pre_v", 32'(l2_valid), 32'd1);
    chk("c.pre_a", l2_addr, 32'h710);
    rst = 1'b1;
    evict(32'h220, H);
    rst = 1'b0;
    chk_all("c.rst", L, '0, L, L, '0, '0, L);
    for (int i = 0; i < 3; i++) begin
      idle(H);
      chk($sformatf("c.post%0d_v", i), 32'(l2_valid), 32'd0);
    end
    evict(32'h220, H);
    chk("c.ev_u", 32'(anneal_unhit), 32'd0);
`ifdef PREF_STAT_EN
    chk("c.st_iss", stat_issued, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
